// File: rtl/data_mem_responder_if.sv
// data_mem_responder_if
//   Groups the MEM-stage data bus between a pipeline (master) and the data
//   memory responder (slave).
//   master: drives DataAddr, MemOp, MemRead, MemWrite, MemDataIn;
//           receives MemReadDataOut, ToHost, ToHostValid, Fault, FaultAddr.
//   slave : the mirror image.
interface data_mem_responder_if;
    logic [31:0] DataAddr;
    logic [2:0]  MemOp;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] MemDataIn;
    logic [31:0] MemReadDataOut;
    logic [31:0] ToHost;
    logic        ToHostValid;
    logic        Fault;
    logic [31:0] FaultAddr;

    modport master (
        output DataAddr, MemOp, MemRead, MemWrite, MemDataIn,
        input  MemReadDataOut, ToHost, ToHostValid, Fault, FaultAddr
    );

    modport slave (
        input  DataAddr, MemOp, MemRead, MemWrite, MemDataIn,
        output MemReadDataOut, ToHost, ToHostValid, Fault, FaultAddr
    );
endinterface

// File: rtl/data_mem_responder.sv
// data_mem_responder
//   Single-cycle data memory for a RISC-V style MEM stage: byte-addressed RAM
//   of DEPTH_WORDS 32-bit words, a host-output MMIO register (TOHOST_ADDR)
//   and a free-running read-only cycle counter (CYCLE_ADDR).
//   Loads are combinational; stores commit at the rising edge.
//   Ports:
//     clk, reset - single clock, synchronous active-high reset
//     bus        - slave side of data_mem_responder_if (request in,
//                  load data / ToHost / ToHostValid / Fault / FaultAddr out)
module data_mem_responder #(
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] TOHOST_ADDR = 32'h8000_0000,
    parameter logic [31:0] CYCLE_ADDR  = 32'h8000_0004
) (
    input  logic                 clk,
    input  logic                 reset,
    data_mem_responder_if.slave  bus
);
    localparam int AW = $clog2(DEPTH_WORDS);

    logic [31:0] mem [DEPTH_WORDS];

    logic [31:0] tohost_q, tohost_d;
    logic        tohost_vld_q, tohost_vld_d;
    logic        fault_q, fault_d;
    logic [31:0] fault_addr_q, fault_addr_d;
    logic [31:0] cycle_q, cycle_d;

    logic          op_byte, op_half, op_word, op_bad;
    logic          hit_ram, hit_tohost, hit_cycle;
    logic          active, acc_fault, ram_we;
    logic [3:0]    be;
    logic [31:0]   wdata;
    logic [31:0]   rword;
    logic [7:0]    lane_b;
    logic [15:0]   lane_h;
    logic [AW-1:0] widx;

    always_comb begin
        widx    = bus.DataAddr[AW+1:2];
        op_byte = (bus.MemOp[1:0] == 2'b00);
        op_half = (bus.MemOp[1:0] == 2'b01);
        op_word = (bus.MemOp == 3'b010);
        // 011, 110, 111 are not legal access types
        op_bad  = (bus.MemOp[1:0] == 2'b11) || (bus.MemOp == 3'b110);

        hit_ram    = ({1'b0, bus.DataAddr} < 33'(4 * DEPTH_WORDS));
        // MMIO registers decode on the word so sub-word lanes are reachable
        hit_tohost = (bus.DataAddr[31:2] == TOHOST_ADDR[31:2]);
        hit_cycle  = (bus.DataAddr[31:2] == CYCLE_ADDR[31:2]);

        active    = bus.MemRead || bus.MemWrite;
        acc_fault = active && (
                        op_bad
                     || (op_half && bus.DataAddr[0])
                     || (op_word && (bus.DataAddr[1:0] != 2'b00))
                     || (!hit_ram && !hit_tohost && !hit_cycle)
                     || (bus.MemRead && bus.MemWrite)
                     || (bus.MemWrite && bus.MemOp[2]));

        // Store lane enables and lane-aligned store data
        be = 4'b1111;
        if (op_byte)      be = 4'b0001 << bus.DataAddr[1:0];
        else if (op_half) be = 4'b0011 << bus.DataAddr[1:0];
        wdata = bus.MemDataIn << {bus.DataAddr[1:0], 3'b000};

        // Stores in a reset cycle are dropped; cycle counter ignores stores
        ram_we = bus.MemWrite && !acc_fault && !reset && hit_ram;

        // Load path
        if (hit_tohost)     rword = tohost_q;
        else if (hit_cycle) rword = cycle_q;
        else                rword = mem[widx];
        lane_b = rword[{bus.DataAddr[1:0], 3'b000} +: 8];
        lane_h = rword[{bus.DataAddr[1], 4'b0000} +: 16];

        bus.MemReadDataOut = 32'h0;
        if (bus.MemRead && !acc_fault) begin
            if (op_byte)
                bus.MemReadDataOut = bus.MemOp[2] ? {24'h0, lane_b}
                                                  : {{24{lane_b[7]}}, lane_b};
            else if (op_half)
                bus.MemReadDataOut = bus.MemOp[2] ? {16'h0, lane_h}
                                                  : {{16{lane_h[15]}}, lane_h};
            else
                bus.MemReadDataOut = rword;
        end

        // Next state
        tohost_d     = tohost_q;
        tohost_vld_d = 1'b0;
        if (bus.MemWrite && !acc_fault && hit_tohost) begin
            tohost_vld_d = 1'b1;
            for (int b = 0; b < 4; b++)
                if (be[b]) tohost_d[8*b +: 8] = wdata[8*b +: 8];
        end
        fault_d      = fault_q || acc_fault;
        fault_addr_d = (acc_fault && !fault_q) ? bus.DataAddr : fault_addr_q;
        cycle_d      = cycle_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tohost_q     <= 32'h0;
            tohost_vld_q <= 1'b0;
            fault_q      <= 1'b0;
            fault_addr_q <= 32'h0;
            cycle_q      <= 32'h0;
        end else begin
            tohost_q     <= tohost_d;
            tohost_vld_q <= tohost_vld_d;
            fault_q      <= fault_d;
            fault_addr_q <= fault_addr_d;
            cycle_q      <= cycle_d;
        end
    end

    // RAM is never cleared; per-lane write enables
    always_ff @(posedge clk) begin
        if (ram_we)
            for (int b = 0; b < 4; b++)
                if (be[b]) mem[widx][8*b +: 8] <= wdata[8*b +: 8];
    end

    assign bus.ToHost      = tohost_q;
    assign bus.ToHostValid = tohost_vld_q;
    assign bus.Fault       = fault_q;
    assign bus.FaultAddr   = fault_addr_q;
endmodule

// File: tb/tb_data_mem_responder.sv
module tb_data_mem_responder;
    localparam logic [31:0] TH  = 32'h8000_0000;
    localparam logic [31:0] CYC = 32'h8000_0004;
    localparam logic [2:0] LB = 3'b000, LH = 3'b001, LW = 3'b010,
                           LBU = 3'b100, LHU = 3'b101;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad = 0;

    data_mem_responder_if bus ();

    data_mem_responder #(
        .DEPTH_WORDS(1024), .TOHOST_ADDR(TH), .CYCLE_ADDR(CYC)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [2:0]  op;
        logic [31:0] addr;
        logic [31:0] din;
        logic [31:0] exp_rd;   // combinational load data in the same cycle
        logic [31:0] exp_th;   // ToHost after the edge
        logic        exp_thv;  // ToHostValid after the edge
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic rd, logic wr, logic [2:0] op, logic [31:0] addr,
                                logic [31:0] din, logic [31:0] er, logic [31:0] eth,
                                logic ethv);
        vec_t v;
        v.rd = rd; v.wr = wr; v.op = op; v.addr = addr; v.din = din;
        v.exp_rd = er; v.exp_th = eth; v.exp_thv = ethv;
        return v;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %08h want %08h", name, act, exp);
        end
    endtask

    task automatic drive(logic rd, logic wr, logic [2:0] op, logic [31:0] addr,
                         logic [31:0] din);
        bus.MemRead = rd; bus.MemWrite = wr; bus.MemOp = op;
        bus.DataAddr = addr; bus.MemDataIn = din;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, LW, 32'h0, 32'h0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        idle();
        tick();
        tick();
        chk("rst_tohost", bus.ToHost, 32'h0);
        chk("rst_thv",    {31'h0, bus.ToHostValid}, 32'h0);
        chk("rst_fault",  {31'h0, bus.Fault}, 32'h0);
        chk("rst_faddr",  bus.FaultAddr, 32'h0);
        reset = 1'b0;

        //         rd    wr    op   addr          din            exp_rd        exp_th        thv
        tbl.push_back(mk(1'b0, 1'b1, LW,  32'h10,       32'hDEADBEEF, 32'h0,        32'h0,        1'b0));
        tbl.push_back(mk(1'b1, 1'b0, LW,  32'h10,       32'h0,        32'hDEADBEEF, 32'h0,        1'b0));
        tbl.push_back(mk(1'b1, 1'b0, LB,  32'h13,       32'h0,        32'hFFFFFFDE, 32'h0,        1'b0));
        tbl.push_back(mk(1'b1, 1'b0, LBU, 32'h13,       32'h0,        32'h000000DE, 32'h0,        1'b0));
        tbl.push_back(mk(1'b1, 1'b0, LH,  32'h12,       32'h0,        32'hFFFFDEAD, 32'h0,        1'b0));
        tbl.push_back(mk(1'b1, 1'b0, LHU, 32'h12,       32'h0,        32'h0000DEAD, 32'h0,        1'b0));
        tbl.push_back(mk(1'b1, 1'b0, LB,  32'h10,       32'h0,        32'hFFFFFFEF, 32'h0,        1'b0));
        tbl.push_back(mk(1'b0, 1'b1, LW,  32'h20,       32'h11223344, 32'h0,        32'h0,        1'b0));
        tbl.push_back(mk(1'b0, 1'b1, LB,  32'h21,       32'hFFFFFFAA, 32'h0,        32'h0,        1'b0));
        tbl.push_back(mk(1'b0, 1'b1, LH,  32'h22,       32'h12345566, 32'h0,        32'h0,        1'b0));
        tbl.push_back(mk(1'b1, 1'b0, LW,  32'h20,       32'h0,        32'h5566AA44, 32'h0,        1'b0));
        tbl.push_back(mk(1'b0, 1'b1, LW,  32'h0,        32'h01020304, 32'h0,        32'h0,        1'b0));
        tbl.push_back(mk(1'b0, 1'b1, LW,  32'hFFC,      32'hCAFEF00D, 32'h0,        32'h0,        1'b0));
        tbl.push_back(mk(1'b1, 1'b0, LW,  32'hFFC,      32'h0,        32'hCAFEF00D, 32'h0,        1'b0));
        tbl.push_back(mk(1'b0, 1'b0, 3'b111, 32'h3,     32'hFFFFFFFF, 32'h0,        32'h0,        1'b0));
        tbl.push_back(mk(1'b0, 1'b1, LW,  TH,           32'h12345678, 32'h0,        32'h12345678, 1'b1));
        tbl.push_back(mk(1'b0, 1'b1, LB,  TH + 32'd1,   32'h000000FF, 32'h0,        32'h1234FF78, 1'b1));
        tbl.push_back(mk(1'b1, 1'b0, LW,  TH,           32'h0,        32'h1234FF78, 32'h1234FF78, 1'b0));
        tbl.push_back(mk(1'b1, 1'b0, LH,  TH + 32'd2,   32'h0,        32'h00001234, 32'h1234FF78, 1'b0));
        tbl.push_back(mk(1'b1, 1'b0, LBU, TH + 32'd1,   32'h0,        32'h000000FF, 32'h1234FF78, 1'b0));
        tbl.push_back(mk(1'b1, 1'b0, LB,  TH + 32'd1,   32'h0,        32'hFFFFFFFF, 32'h1234FF78, 1'b0));
        tbl.push_back(mk(1'b0, 1'b1, LW,  CYC,          32'hABCDABCD, 32'h0,        32'h1234FF78, 1'b0));
        tbl.push_back(mk(1'b1, 1'b0, LW,  32'h0,        32'h0,        32'h01020304, 32'h1234FF78, 1'b0));

        foreach (tbl[i]) begin
            drive(tbl[i].rd, tbl[i].wr, tbl[i].op, tbl[i].addr, tbl[i].din);
            #1;
            chk($sformatf("v%0d_rdata", i), bus.MemReadDataOut, tbl[i].exp_rd);
            tick();
            chk($sformatf("v%0d_fault", i), {31'h0, bus.Fault}, 32'h0);
            chk($sformatf("v%0d_tohost", i), bus.ToHost, tbl[i].exp_th);
            chk($sformatf("v%0d_thv", i), {31'h0, bus.ToHostValid}, {31'h0, tbl[i].exp_thv});
        end

        // Misaligned word load faults, returns 0, first fault captured
        drive(1'b1, 1'b0, LW, 32'h6, 32'h0);
        #1 chk("flt_lw_rdata", bus.MemReadDataOut, 32'h0);
        tick();
        chk("flt_set", {31'h0, bus.Fault}, 32'h1);
        chk("flt_addr", bus.FaultAddr, 32'h6);
        // Second faulting store: address kept, RAM untouched
        drive(1'b0, 1'b1, LH, 32'h3, 32'hBEEF);
        tick();
        chk("flt_addr_kept", bus.FaultAddr, 32'h6);
        chk("flt_sticky", {31'h0, bus.Fault}, 32'h1);
        drive(1'b1, 1'b0, LW, 32'h0, 32'h0);
        #1 chk("flt_ram_unch", bus.MemReadDataOut, 32'h01020304);
        // Other faulting loads read back 0
        drive(1'b1, 1'b0, LW, 32'h11, 32'h0);
        #1 chk("flt_lw_mis", bus.MemReadDataOut, 32'h0);
        drive(1'b1, 1'b0, LH, 32'h11, 32'h0);
        #1 chk("flt_lh_mis", bus.MemReadDataOut, 32'h0);
        drive(1'b1, 1'b0, 3'b011, 32'h10, 32'h0);
        #1 chk("flt_badop", bus.MemReadDataOut, 32'h0);
        drive(1'b1, 1'b0, LW, 32'h1000, 32'h0);
        #1 chk("flt_range", bus.MemReadDataOut, 32'h0);
        drive(1'b1, 1'b1, LW, 32'h10, 32'h0);
        #1 chk("flt_rdwr", bus.MemReadDataOut, 32'h0);
        // Store with unsigned op faults and must not write
        drive(1'b0, 1'b1, LBU, 32'h10, 32'h0);
        tick();
        drive(1'b1, 1'b0, LW, 32'h10, 32'h0);
        #1 chk("flt_sbu_nowr", bus.MemReadDataOut, 32'hDEADBEEF);
        // Faulting store to ToHost must not update it
        drive(1'b0, 1'b1, LW, TH + 32'd2, 32'h0);
        tick();
        chk("flt_th_unch", bus.ToHost, 32'h1234FF78);
        chk("flt_th_nov", {31'h0, bus.ToHostValid}, 32'h0);

        // Reset with a store presented: store dropped, state cleared
        reset = 1'b1;
        drive(1'b0, 1'b1, LW, 32'h10, 32'h0);
        tick();
        reset = 1'b0;
        idle();
        chk("rst2_fault",  {31'h0, bus.Fault}, 32'h0);
        chk("rst2_faddr",  bus.FaultAddr, 32'h0);
        chk("rst2_tohost", bus.ToHost, 32'h0);
        drive(1'b1, 1'b0, LW, CYC, 32'h0);
        #1 chk("rst2_cycle", bus.MemReadDataOut, 32'h0);
        drive(1'b1, 1'b0, LW, 32'h10, 32'h0);
        #1 chk("rst2_ram", bus.MemReadDataOut, 32'hDEADBEEF);

        // Cycle counter after 10 non-reset edges
        idle();
        repeat (10) tick();
        drive(1'b1, 1'b0, LW, CYC, 32'h0);
        #1 chk("cyc_lw", bus.MemReadDataOut, 32'd10);
        drive(1'b1, 1'b0, LBU, CYC, 32'h0);
        #1 chk("cyc_lbu", bus.MemReadDataOut, 32'h0000000A);
        drive(1'b1, 1'b0, LHU, CYC + 32'd2, 32'h0);
        #1 chk("cyc_lhu_hi", bus.MemReadDataOut, 32'h0);
        tick();
        chk("cyc_nofault", {31'h0, bus.Fault}, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running want finished");
        $fatal(1);
    end
endmodule
